// File: rtl/firtrig_pkg.sv
// Shared definitions for the rolling-sum trigger stage: default widths and
// discriminator state encoding.
package firtrig_pkg;

  localparam int SUMBITS_DEF   = 18;
  localparam int HYSTBITS_DEF  = 12;
  localparam int HOLDBITS_DEF  = 16;
  localparam int WIDTHBITS_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/peak_width_tracker.sv
// Running signed maximum and saturating group counter for one over-threshold
// pulse. Load starts a pulse, update folds in one more evaluated group.
module peak_width_tracker #(
  parameter int SUMBITS   = 18,
  parameter int WIDTHBITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 update,
  input  logic [SUMBITS-1:0]   sum,
  output logic [SUMBITS-1:0]   peak,
  output logic [WIDTHBITS-1:0] width
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak  <= '0;
      width <= '0;
    end else if (clear) begin
      peak  <= '0;
      width <= '0;
    end else if (load) begin
      peak  <= sum;
      width <= WIDTHBITS'(1);
    end else if (update) begin
      if ($signed(sum) > $signed(peak)) peak <= sum;
      // Counter sticks at all-ones rather than wrapping on very long pulses.
      if (width != '1) width <= width + WIDTHBITS'(1);
    end
  end

endmodule

// File: rtl/sum_threshold_trigger.sv
// Threshold discriminator on the rolling-sum stream: trigger on crossing,
// hysteretic release, holdoff before re-arm, peak/width report per pulse.
module sum_threshold_trigger
  import firtrig_pkg::*;
#(
  parameter int SUMBITS   = SUMBITS_DEF,
  parameter int HYSTBITS  = HYSTBITS_DEF,
  parameter int HOLDBITS  = HOLDBITS_DEF,
  parameter int WIDTHBITS = WIDTHBITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SUMBITS-1:0]   sum_in,
  input  logic                 valid_in,
  input  logic                 hold_in,
  input  logic                 enable,
  input  logic [SUMBITS-1:0]   thresh,
  input  logic [HYSTBITS-1:0]  hyst,
  input  logic [HOLDBITS-1:0]  holdoff,
  output logic                 trig,
  output logic                 over,
  output logic [SUMBITS-1:0]   peak,
  output logic [WIDTHBITS-1:0] width,
  output logic                 rep_valid,
  output state_t               dbg_state
);

  // Stream contract: valid_in & enable keep the discriminator alive (dropping
  // either aborts to IDLE); a group is evaluated only when hold_in is low.
  state_t              state, state_next;
  logic [HOLDBITS-1:0] cnt, cnt_next;
  logic                trig_next, rep_next;
  logic                trk_load, trk_update, trk_clear;
  logic                ev, live;
  logic                at_thresh, below_rel;
  logic signed [SUMBITS:0] rel_level, sum_ext;
  logic [SUMBITS-1:0]   trk_peak;
  logic [WIDTHBITS-1:0] trk_width;

  assign live = valid_in & enable;
  assign ev   = live & ~hold_in;

  // One extra bit so thresh - hyst cannot wrap near the negative limit.
  assign rel_level = $signed({thresh[SUMBITS-1], thresh})
                   - $signed({{(SUMBITS + 1 - HYSTBITS){1'b0}}, hyst});
  assign sum_ext   = $signed({sum_in[SUMBITS-1], sum_in});
  assign at_thresh = $signed(sum_in) >= $signed(thresh);
  assign below_rel = sum_ext < rel_level;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    trig_next  = 1'b0;
    rep_next   = 1'b0;
    trk_load   = 1'b0;
    trk_update = 1'b0;
    trk_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        if (live) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (ev && at_thresh) begin
          state_next = S_ACTIVE;
          trig_next  = 1'b1;
          trk_load   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ev) begin
          if (below_rel) begin
            rep_next = 1'b1;
            if (holdoff == '0) begin
              state_next = S_ARMED;
            end else begin
              state_next = S_HOLDOFF;
              cnt_next   = holdoff;
            end
          end else begin
            trk_update = 1'b1;
          end
        end
      end
      S_HOLDOFF: begin
        if (ev) begin
          if (cnt <= HOLDBITS'(1)) begin
            state_next = S_ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - HOLDBITS'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (!live) begin
      state_next = S_IDLE;
      trig_next  = 1'b0;
      rep_next   = 1'b0;
      trk_load   = 1'b0;
      trk_update = 1'b0;
      trk_clear  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      trig      <= 1'b0;
      rep_valid <= 1'b0;
      peak      <= '0;
      width     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      trig      <= trig_next;
      rep_valid <= rep_next;
      // The releasing group is not folded in, so the tracker holds the final result.
      if (rep_next) begin
        peak  <= trk_peak;
        width <= trk_width;
      end
    end
  end

  peak_width_tracker #(
    .SUMBITS   (SUMBITS),
    .WIDTHBITS (WIDTHBITS)
  ) u_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (trk_clear),
    .load    (trk_load),
    .update  (trk_update),
    .sum     (sum_in),
    .peak    (trk_peak),
    .width   (trk_width)
  );

  assign over      = (state == S_ACTIVE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sum_threshold_trigger.sv
// Directed bench for sum_threshold_trigger: table of per-cycle vectors plus
// hand-written sequences for abort, saturation, negative limit and reset.
module tb_sum_threshold_trigger;
  import firtrig_pkg::*;

  localparam int SB = 18;
  localparam int HB = 12;
  localparam int DB = 16;
  localparam int WB = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [SB-1:0] sum_in = '0;
  logic          valid_in = 1'b0;
  logic          hold_in = 1'b0;
  logic          enable = 1'b0;
  logic [SB-1:0] thresh = '0;
  logic [HB-1:0] hyst = '0;
  logic [DB-1:0] holdoff = '0;

  logic          trig, over, rep_valid;
  logic [SB-1:0] peak;
  logic [WB-1:0] width;
  state_t        dbg_state;

  logic          trig_w4, over_w4, rep_valid_w4;
  logic [SB-1:0] peak_w4;
  logic [3:0]    width_w4;
  state_t        dbg_state_w4;

  typedef struct {
    string                 name;
    logic                  v, e, h;
    logic signed [SB-1:0]  sum;
    logic                  t, o, r;
    logic signed [SB-1:0]  pk;
    logic [WB-1:0]         wd;
  } vec_t;

  vec_t              vecs[$];
  logic [SB+WB-1:0]  exp_q[$];
  logic [SB+WB-1:0]  got_q[$];
  int                checks = 0;
  int                failures = 0;

  sum_threshold_trigger dut (
    .clk(clk), .reset_n(reset_n), .sum_in(sum_in), .valid_in(valid_in),
    .hold_in(hold_in), .enable(enable), .thresh(thresh), .hyst(hyst),
    .holdoff(holdoff), .trig(trig), .over(over), .peak(peak), .width(width),
    .rep_valid(rep_valid), .dbg_state(dbg_state)
  );

  sum_threshold_trigger #(.WIDTHBITS(4)) dut_w4 (
    .clk(clk), .reset_n(reset_n), .sum_in(sum_in), .valid_in(valid_in),
    .hold_in(hold_in), .enable(enable), .thresh(thresh), .hyst(hyst),
    .holdoff(holdoff), .trig(trig_w4), .over(over_w4), .peak(peak_w4),
    .width(width_w4), .rep_valid(rep_valid_w4), .dbg_state(dbg_state_w4)
  );

  // clock
  always #5 clk = ~clk;

  // report monitor
  always @(negedge clk) begin
    if (reset_n && rep_valid) got_q.push_back({peak, width});
  end

  function automatic vec_t mk(string n, logic v, logic e, logic h, int s,
                              logic t, logic o, logic r, int pk, int wd);
    vec_t x;
    x.name = n; x.v = v; x.e = e; x.h = h; x.sum = SB'(s);
    x.t = t; x.o = o; x.r = r; x.pk = SB'(pk); x.wd = WB'(wd);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int t, input int hy, input int ho);
    thresh  = SB'(t);
    hyst    = HB'(hy);
    holdoff = DB'(ho);
  endtask

  // Called at posedge+1: drive one group, cross one edge, check registered outputs.
  task automatic run_row(input vec_t r);
    valid_in = r.v;
    enable   = r.e;
    hold_in  = r.h;
    sum_in   = r.sum;
    if (r.r) exp_q.push_back({r.pk, r.wd});
    @(posedge clk);
    #1;
    check({r.name, ".trig"},      32'(trig),      32'(r.t));
    check({r.name, ".over"},      32'(over),      32'(r.o));
    check({r.name, ".rep_valid"}, 32'(rep_valid), 32'(r.r));
    check({r.name, ".peak"},      32'(peak),      32'(r.pk));
    check({r.name, ".width"},     32'(width),     32'(r.wd));
  endtask

  initial begin
    // pulse with release, holdoff, pause handling (thresh 100, hyst 10, holdoff 2)
    vecs.push_back(mk("t1_arm",    1,1,0,   0, 0,0,0,   0,0));
    vecs.push_back(mk("t1_s50",    1,1,0,  50, 0,0,0,   0,0));
    vecs.push_back(mk("t1_cross",  1,1,0, 120, 1,1,0,   0,0));
    vecs.push_back(mk("t1_s150",   1,1,0, 150, 0,1,0,   0,0));
    vecs.push_back(mk("t1_s130",   1,1,0, 130, 0,1,0,   0,0));
    vecs.push_back(mk("t1_s95",    1,1,0,  95, 0,1,0,   0,0));
    vecs.push_back(mk("t1_rel",    1,1,0,  80, 0,0,1, 150,4));
    vecs.push_back(mk("t2_ho1",    1,1,0, 200, 0,0,0, 150,4));
    vecs.push_back(mk("t2_ho2",    1,1,0, 200, 0,0,0, 150,4));
    vecs.push_back(mk("t2_trig",   1,1,0, 200, 1,1,0, 150,4));
    vecs.push_back(mk("t2_rel",    1,1,0,  50, 0,0,1, 200,1));
    vecs.push_back(mk("t2_ho3",    1,1,0,   0, 0,0,0, 200,1));
    vecs.push_back(mk("t2_ho4",    1,1,0,   0, 0,0,0, 200,1));
    vecs.push_back(mk("t3_paused", 1,1,1, 500, 0,0,0, 200,1));
    vecs.push_back(mk("t3_paused2",1,1,1, 500, 0,0,0, 200,1));
    vecs.push_back(mk("t3_go",     1,1,0, 500, 1,1,0, 200,1));
    vecs.push_back(mk("t3_pause_a",1,1,1, 500, 0,1,0, 200,1));

    // reset
    set_cfg(100, 10, 2);
    #12;
    check("rst.trig",  32'(trig),      32'd0);
    check("rst.over",  32'(over),      32'd0);
    check("rst.rep",   32'(rep_valid), 32'd0);
    check("rst.peak",  32'(peak),      32'd0);
    check("rst.width", 32'(width),     32'd0);
    check("rst.state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.state", 32'(dbg_state), 32'(S_IDLE));

    foreach (vecs[i]) run_row(vecs[i]);

    // abort mid-pulse, then re-enable
    run_row(mk("t4_abort", 1,0,0, 500, 0,0,0, 200,1));
    check("t4_abort.state", 32'(dbg_state), 32'(S_IDLE));
    run_row(mk("t4_rearm", 1,1,0, 120, 0,0,0, 200,1));
    run_row(mk("t4_trig",  1,1,0, 120, 1,1,0, 200,1));

    // zero hysteresis: release as soon as the sum drops below thresh
    set_cfg(100, 0, 2);
    run_row(mk("h0_stay", 1,1,0, 100, 0,1,0, 200,1));
    run_row(mk("h0_rel",  1,1,0,  99, 0,0,1, 120,2));
    run_row(mk("h0_ho1",  1,1,0,   0, 0,0,0, 120,2));
    run_row(mk("h0_ho2",  1,1,0,   0, 0,0,0, 120,2));

    // zero holdoff: release goes straight back to ARMED
    set_cfg(100, 10, 0);
    run_row(mk("z_trig",  1,1,0, 150, 1,1,0, 120,2));
    run_row(mk("z_rel",   1,1,0,   0, 0,0,1, 150,1));
    run_row(mk("z_trig2", 1,1,0, 150, 1,1,0, 150,1));
    run_row(mk("z_rel2",  1,1,0,   0, 0,0,1, 150,1));

    // long pulse: 20 groups, saturates the 4-bit width instance
    run_row(mk("w_trig", 1,1,0, 200, 1,1,0, 150,1));
    for (int i = 0; i < 19; i++) run_row(mk("w_run", 1,1,0, 200, 0,1,0, 150,1));
    run_row(mk("w_rel", 1,1,0, 0, 0,0,1, 200,20));
    check("w4.rep_valid", 32'(rep_valid_w4), 32'd1);
    check("w4.peak",      32'(peak_w4),      32'd200);
    check("w4.width",     32'(width_w4),     32'd15);

    // most negative threshold with full hysteresis: release level must not wrap
    set_cfg(-131072, 4095, 0);
    run_row(mk("n_trig",  1,1,0, -131072, 1,1,0, 200,20));
    run_row(mk("n_stay1", 1,1,0, -131072, 0,1,0, 200,20));
    run_row(mk("n_stay2", 1,1,0, -100000, 0,1,0, 200,20));
    check("n_stay2.state", 32'(dbg_state), 32'(S_ACTIVE));

    // asynchronous reset mid-pulse clears outputs without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.trig",     32'(trig),      32'd0);
    check("arst.over",     32'(over),      32'd0);
    check("arst.rep",      32'(rep_valid), 32'd0);
    check("arst.peak",     32'(peak),      32'd0);
    check("arst.width",    32'(width),     32'd0);
    check("arst.state",    32'(dbg_state), 32'(S_IDLE));
    check("arst.w4_width", 32'(width_w4),  32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    enable   = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // scoreboard: every report strobe in order
    check("rep_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [SB+WB-1:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("rep_peak",  32'(g[SB+WB-1:WB]), 32'(e[SB+WB-1:WB]));
      check("rep_width", 32'(g[WB-1:0]),     32'(e[WB-1:0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
